// File: rtl/window_scan_ctrl.sv
// window_scan_ctrl: steps a FEATURE_WIDTH x FEATURE_HEIGHT window across one
// image frame. It hands each origin to the pixel fetcher and checks the
// EOT-tagged pixel stream against the expected window shape. It then collects
// the classifier verdict and reports the origin of every detected window.
module window_scan_ctrl #(
  parameter int IMG_WIDTH      = 320,
  parameter int IMG_HEIGHT     = 240,
  parameter int FEATURE_WIDTH  = 24,
  parameter int FEATURE_HEIGHT = 24,
  parameter int STEP           = 1,
  parameter int W_X            = $clog2(IMG_WIDTH),
  parameter int W_Y            = $clog2(IMG_HEIGHT)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           win_valid,
  input  logic           win_ready,
  output logic [W_X-1:0] win_x,
  output logic [W_Y-1:0] win_y,
  input  logic           px_hs,
  input  logic [1:0]     px_eot,
  input  logic           result_valid,
  output logic           result_ready,
  input  logic           result_detect,
  output logic           det_valid,
  input  logic           det_ready,
  output logic [W_X-1:0] det_x,
  output logic [W_Y-1:0] det_y,
  output logic           err
);

  // Pixel count per window and the column position inside the current row.
  localparam int N   = FEATURE_WIDTH * FEATURE_HEIGHT;
  localparam int W_C = $clog2(N + 1);
  localparam int W_F = $clog2(FEATURE_WIDTH + 1);

  localparam logic [W_C-1:0] CNT_LAST = W_C'(N - 1);
  localparam logic [W_F-1:0] COL_LAST = W_F'(FEATURE_WIDTH - 1);

  // Last legal origins and the stride, one bit wider than the coordinates so
  // that origin + STEP can never wrap before it is compared.
  localparam logic [W_X:0] X_LAST = (W_X + 1)'(IMG_WIDTH - FEATURE_WIDTH);
  localparam logic [W_Y:0] Y_LAST = (W_Y + 1)'(IMG_HEIGHT - FEATURE_HEIGHT);
  localparam logic [W_X:0] X_STEP = (W_X + 1)'(STEP);
  localparam logic [W_Y:0] Y_STEP = (W_Y + 1)'(STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_STREAM,
    S_RESULT,
    S_REPORT,
    S_DONE
  } state_t;

  state_t         state_reg;
  logic [W_C-1:0] cnt_reg;
  logic [W_F-1:0] col_reg;

  logic [W_X:0]   x_inc;
  logic [W_Y:0]   y_inc;
  logic           x_wrap;
  logic           frame_end;
  logic [W_X-1:0] adv_x;
  logic [W_Y-1:0] adv_y;
  logic           adv_req;
  logic           row_end_exp;

  // Next origin in raster order and whether it falls off the bottom of the frame.
  always_comb begin
    x_inc     = {1'b0, win_x} + X_STEP;
    y_inc     = {1'b0, win_y} + Y_STEP;
    x_wrap    = (x_inc > X_LAST);
    frame_end = x_wrap && (y_inc > Y_LAST);
    adv_x     = x_wrap ? '0 : x_inc[W_X-1:0];
    adv_y     = x_wrap ? y_inc[W_Y-1:0] : win_y;
    adv_req   = ((state_reg == S_RESULT) && result_valid && !result_detect) ||
                ((state_reg == S_REPORT) && det_ready);
    row_end_exp = (col_reg == COL_LAST);
  end

  // Scan sequencer: all control outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= '0;
      col_reg      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      win_valid    <= 1'b0;
      win_x        <= '0;
      win_y        <= '0;
      result_ready <= 1'b0;
      det_valid    <= 1'b0;
      det_x        <= '0;
      det_y        <= '0;
      err          <= 1'b0;
    end else begin
      // Pixels arriving while no window is being streamed are a protocol error.
      if (px_hs && (state_reg != S_STREAM)) begin
        err <= 1'b1;
      end

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            win_x     <= '0;
            win_y     <= '0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end

        // The first ISSUE cycle after start only sets up the origin; after
        // an advance, win_valid is already high on entry.
        S_ISSUE: begin
          if (!win_valid) begin
            win_valid <= 1'b1;
          end else if (win_ready) begin
            win_valid <= 1'b0;
            cnt_reg   <= '0;
            col_reg   <= '0;
            state_reg <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (px_hs) begin
            cnt_reg <= cnt_reg + 1'b1;
            col_reg <= row_end_exp ? '0 : col_reg + 1'b1;
            if (px_eot[0] != row_end_exp) begin
              err <= 1'b1;
            end
            if (px_eot[1]) begin
              if (cnt_reg != CNT_LAST) begin
                err <= 1'b1;
              end
              result_ready <= 1'b1;
              state_reg    <= S_RESULT;
            end else if (cnt_reg == CNT_LAST) begin
              err          <= 1'b1;
              result_ready <= 1'b1;
              state_reg    <= S_RESULT;
            end
          end
        end

        S_RESULT: begin
          if (result_valid) begin
            result_ready <= 1'b0;
            if (result_detect) begin
              det_x     <= win_x;
              det_y     <= win_y;
              det_valid <= 1'b1;
              state_reg <= S_REPORT;
            end
          end
        end

        S_REPORT: begin
          if (det_ready) begin
            det_valid <= 1'b0;
          end
        end

        S_DONE: begin
          done      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      // Move to the next origin, or close the frame after the last window.
      if (adv_req) begin
        if (frame_end) begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= S_DONE;
        end else begin
          win_x     <= adv_x;
          win_y     <= adv_y;
          win_valid <= 1'b1;
          state_reg <= S_ISSUE;
        end
      end
    end
  end

endmodule
